vga_scan_reader: RTL
====================

VGA_SCAN_READER -- requirements
Module: vga_scan_reader

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical porch and sync widths in lines.
REQ-004 Parameter ADDR_W, 24, video-memory address width.
REQ-005 Clock  input  1  system clock, 50 MHz; single clock domain.
REQ-006 Reset  input  1  synchronous, active-low reset.
REQ-007 oReadAddress  output  ADDR_W  video-memory read address, presented to the RAM read port.
REQ-008 iPixelData  input  3  {R,G,B} from the RAM read port, valid one Clock after the address.
REQ-009 oVGA_R, oVGA_G, oVGA_B  output  1 each  registered colour outputs.
REQ-010 oHSync, oVSync  output  1 each  registered sync outputs, active-low.
REQ-011 oBlank  output  1  high while the output pixel is outside the visible area.
REQ-012 oFrameStart  output  1  one-Clock pulse at the pixel tick where output pixel (0,0) appears.

Function
REQ-013 Pixel tick: internal enable, toggles every Clock; the first tick is the second rising edge after Reset deasserts (25 MHz pixel rate).
REQ-014 Horizontal counter: 0..799 (sum of H parameters minus 1); advances on each tick; wraps to 0.
REQ-015 Vertical counter: 0..524; advances on each tick where H wraps; wraps to 0 when H and V wrap together.
REQ-016 Visible: H < 640 and V < 480.
REQ-017 HSync region: H in 656..751; VSync region: V in 490..491; both use the current counter values.
REQ-018 Address: a linear counter, without a multiplier; equals V*640+H while visible; increments by 1 per visible tick; holds through blanking; resets to 0 when V wraps.
REQ-019 Address range: maximum 307199; never exceeds this value.
REQ-020 Pipeline: one pixel tick; on each tick the outputs register iPixelData together with the sync/blank flags of the previous counter position, so colour and sync stay aligned.
REQ-021 Colour gating: oVGA_R/G/B are forced to 0 whenever the aligned position is not visible.
REQ-022 Memory writes by the ALU are asynchronous to the scan; a pixel written mid-frame appears on the first scan that reaches it afterward; no tearing protection is provided.
REQ-023 Outputs change only on pixel ticks; between ticks they hold.
REQ-024 Frame: 800 x 525 ticks = 420000 ticks = 840000 Clocks.

Reset
REQ-025 While Reset = 0 the block enforces: counters 0, address 0, tick enable 0, oHSync = 1, oVSync = 1, RGB = 0, oBlank = 1, oFrameStart = 0.
REQ-026 Reset asserted mid-frame aborts the scan on the next edge; the scan restarts at (0,0) after release; there is no partial-line recovery.
REQ-027 Reset is sampled only on rising Clock edges; there is no asynchronous path.

Structure
REQ-028 The timing constants (H/V visible, porch, and sync widths, plus totals 800/525) are defined in the shared definitions include alongside the opcode defines; the parameters default to them.
REQ-029 There is one sub-module, vga_sync_counter: a parameterised wrap counter with enable, carry-out, and active-low synchronous reset, instantiated for H and V.
REQ-030 There are no RAM instances inside the block; the block is the read-side companion to the VideoMemory write port, and its address connects to that RAM's read address.

Verification
REQ-031 Reset low 5 Clocks, then released -> all outputs at reset values; first counter advance at the 2nd edge after release.
REQ-032 Free-run one line -> oHSync low for exactly 96 ticks (192 Clocks), beginning 656 ticks after line start (+1 tick of pipeline delay).
REQ-033 Free-run one frame -> oVSync low for exactly 2 lines (1600 ticks); oFrameStart pulses once per 840000 Clocks.
REQ-034 RAM model with data = address[2:0] -> the RGB sequence 0,1,..,7 repeats across visible pixels; RGB = 0 during blanking; the address at (639,479) is 307199 and the next frame restarts at 0.
REQ-035 Reset pulsed low at H=300, V=200 -> the next frame starts at (0,0), the address is 0, and no sync glitch shorter than a full pulse appears after release.
REQ-036 Write 3'b100 at address 641 mid-frame, before the scan reaches it -> oVGA_R=1 only at output pixel (1,1) of that frame.

Source files
------------

// File: rtl/vga_scan_reader_pkg.sv
// Shared VGA scan definitions: 640x480 timing constants, the per-position
// flag bundle and a small range helper used by the scan decoder.
package vga_scan_reader_pkg;

    // Horizontal timing in pixels
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // Vertical timing in lines
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Video memory geometry
    localparam int VGA_ADDR_W  = 24;
    localparam int VGA_PIXEL_W = 3;

    // Flags decoded from the current counter position
    typedef struct packed {
        logic visible;
        logic hSyncRegion;
        logic vSyncRegion;
        logic origin;
    } scanFlags_t;

    // Inclusive range test on zero-extended counter values
    function automatic logic inRange(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_reader_sync_counter.sv
// Wrap counter with enable and carry-out; instantiated once per scan axis.
// Carry is asserted in the enabled cycle where the count wraps to zero.
module vga_sync_counter
    import vga_scan_reader_pkg::*;
#(
    parameter int MAX_COUNT = VGA_H_TOTAL - 1,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iEnable,
    output logic [WIDTH-1:0] oCount,
    output logic             oCarry
);

    logic [WIDTH-1:0] countReg;
    logic [WIDTH-1:0] countNext;
    logic             atMax;

    assign atMax = (countReg == WIDTH'(MAX_COUNT));

    // Next count: advance when enabled, wrap to zero after MAX_COUNT
    always_comb begin
        countNext = countReg;
        if (iEnable) begin
            countNext = atMax ? '0 : countReg + WIDTH'(1);
        end
    end

    // Count register with active-low synchronous clear
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

    assign oCount = countReg;
    assign oCarry = iEnable & atMax;

endmodule

// File: rtl/vga_scan_reader.sv
// Read-side VGA scanner: walks the raster at half the system clock, drives
// the video-memory read address and re-times the returned pixel with the
// sync/blank flags of the position it was fetched for.
module vga_scan_reader
    import vga_scan_reader_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int ADDR_W    = VGA_ADDR_W
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_W-1:0]      oReadAddress,
    input  logic [VGA_PIXEL_W-1:0] iPixelData,
    output logic                   oVGA_R,
    output logic                   oVGA_G,
    output logic                   oVGA_B,
    output logic                   oHSync,
    output logic                   oVSync,
    output logic                   oBlank,
    output logic                   oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic                   tickReg;
    logic [HW-1:0]          hCount;
    logic [VW-1:0]          vCount;
    logic                   hCarry;
    logic                   vCarry;
    scanFlags_t             flagsNow;
    logic                   lastVisible;
    logic                   frameWrap;
    logic [ADDR_W-1:0]      addrReg;
    logic [ADDR_W-1:0]      addrNext;
    logic [VGA_PIXEL_W-1:0] gatedPixel;
    logic [VGA_PIXEL_W-1:0] rgbReg;
    logic                   hSyncReg;
    logic                   vSyncReg;
    logic                   blankReg;
    logic                   frameStartReg;

    // Pixel tick: toggles every clock, so the first advance lands on the
    // second edge after reset release
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            tickReg <= 1'b0;
        end else begin
            tickReg <= ~tickReg;
        end
    end

    vga_sync_counter #(
        .MAX_COUNT(H_TOTAL - 1),
        .WIDTH    (HW)
    ) hCounter (
        .Clock  (Clock),
        .Reset  (Reset),
        .iEnable(tickReg),
        .oCount (hCount),
        .oCarry (hCarry)
    );

    vga_sync_counter #(
        .MAX_COUNT(V_TOTAL - 1),
        .WIDTH    (VW)
    ) vCounter (
        .Clock  (Clock),
        .Reset  (Reset),
        .iEnable(hCarry),
        .oCount (vCount),
        .oCarry (vCarry)
    );

    // Decode visibility, sync regions and origin from the live counters
    always_comb begin
        flagsNow             = '0;
        flagsNow.visible     = (32'(hCount) < 32'(H_VISIBLE)) && (32'(vCount) < 32'(V_VISIBLE));
        flagsNow.hSyncRegion = inRange(32'(hCount), 32'(H_VISIBLE + H_FRONT),
                                       32'(H_VISIBLE + H_FRONT + H_SYNC - 1));
        flagsNow.vSyncRegion = inRange(32'(vCount), 32'(V_VISIBLE + V_FRONT),
                                       32'(V_VISIBLE + V_FRONT + V_SYNC - 1));
        flagsNow.origin      = (hCount == '0) && (vCount == '0);
    end

    assign lastVisible = (hCount == HW'(H_VISIBLE - 1)) && (vCount == VW'(V_VISIBLE - 1));
    assign frameWrap   = hCarry & vCarry;

    // Linear address: +1 per visible tick, held through blanking; it drops
    // to zero straight after the final visible pixel so it never passes the
    // last valid location and is already 0 for the next frame
    always_comb begin
        addrNext = addrReg;
        if (tickReg) begin
            if (lastVisible || frameWrap) begin
                addrNext = '0;
            end else if (flagsNow.visible) begin
                addrNext = addrReg + ADDR_W'(1);
            end
        end
    end

    // Address register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addrReg <= '0;
        end else begin
            addrReg <= addrNext;
        end
    end

    // Colour is masked outside the visible window, one bit per channel
    for (genvar gi = 0; gi < VGA_PIXEL_W; gi++) begin : genGate
        assign gatedPixel[gi] = iPixelData[gi] & flagsNow.visible;
    end

    // Output stage: on each tick capture the fetched pixel together with the
    // flags of the position it was fetched for; frame start is a one-clock pulse
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rgbReg        <= '0;
            hSyncReg      <= 1'b1;
            vSyncReg      <= 1'b1;
            blankReg      <= 1'b1;
            frameStartReg <= 1'b0;
        end else begin
            frameStartReg <= tickReg & flagsNow.origin;
            if (tickReg) begin
                rgbReg   <= gatedPixel;
                hSyncReg <= ~flagsNow.hSyncRegion;
                vSyncReg <= ~flagsNow.vSyncRegion;
                blankReg <= ~flagsNow.visible;
            end
        end
    end

    assign oReadAddress = addrReg;
    assign oVGA_R       = rgbReg[2];
    assign oVGA_G       = rgbReg[1];
    assign oVGA_B       = rgbReg[0];
    assign oHSync       = hSyncReg;
    assign oVSync       = vSyncReg;
    assign oBlank       = blankReg;
    assign oFrameStart  = frameStartReg;

endmodule
